// File: rtl/ps2_interface.sv
// PS/2 host port: filtered receive of 11-bit device frames, host-to-device byte send, open-drain pins.
// read_data fires 2 cycles after the filtered 11th falling edge; write is dropped while busy (no queue).
`timescale 1ns/1ps
module ps2_interface #(
    parameter int FILTER_CYCLES  = 8,
    parameter int INHIBIT_CYCLES = 10000,
    parameter int START_CYCLES   = 2000,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire        ps2_clk,
    inout  wire        ps2_data,
    input  logic [7:0] tx_data,
    input  logic       write,
    output logic [7:0] rx_data,
    output logic       read_data,
    output logic       busy,
    output logic       err
);

    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam int CW = 18;

    typedef enum logic [2:0] {
        IDLE, RX_BITS, RX_CHECK, TX_INHIBIT, TX_START, TX_BITS, TX_ACK, TX_WAIT_IDLE
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      clk_sync_q, clk_sync_d, data_sync_q, data_sync_d;
    logic            filt_clk_q, filt_clk_d, filt_data_q, filt_data_d;
    logic [FW-1:0]   filt_clk_cnt_q, filt_clk_cnt_d, filt_data_cnt_q, filt_data_cnt_d;
    logic            clk_prev_q, clk_prev_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [10:0]     rx_shift_q, rx_shift_d;
    logic [8:0]      tx_shift_q, tx_shift_d;
    logic            clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            read_data_q, read_data_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;

    logic fall, timeout, lines_idle, frame_good, timeout_exit;

    assign ps2_clk   = clk_oe_q  ? 1'b0 : 1'bz;
    assign ps2_data  = data_oe_q ? 1'b0 : 1'bz;
    assign rx_data   = rx_data_q;
    assign read_data = read_data_q;
    assign busy      = busy_q;
    assign err       = err_q;

    assign fall       = clk_prev_q & ~filt_clk_q;
    assign timeout    = (cnt_q >= CW'(TIMEOUT_CYCLES));
    assign lines_idle = filt_clk_q & filt_data_q;
    // rx_shift holds {stop, parity, d7..d0, start} once all 11 bits are in
    assign frame_good = ~rx_shift_q[0] & rx_shift_q[10] & (^rx_shift_q[9:1]);

    // Synchronizers and glitch filters: a new level must persist FILTER_CYCLES cycles
    always_comb begin
        clk_sync_d      = {clk_sync_q[0], ps2_clk};
        data_sync_d     = {data_sync_q[0], ps2_data};
        clk_prev_d      = filt_clk_q;
        filt_clk_d      = filt_clk_q;
        filt_clk_cnt_d  = '0;
        filt_data_d     = filt_data_q;
        filt_data_cnt_d = '0;
        if (clk_sync_q[1] != filt_clk_q) begin
            if (filt_clk_cnt_q == FW'(FILTER_CYCLES - 1))
                filt_clk_d = clk_sync_q[1];
            else
                filt_clk_cnt_d = filt_clk_cnt_q + 1'b1;
        end
        if (data_sync_q[1] != filt_data_q) begin
            if (filt_data_cnt_q == FW'(FILTER_CYCLES - 1))
                filt_data_d = data_sync_q[1];
            else
                filt_data_cnt_d = filt_data_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (fall && !filt_data_q)
                    state_d = RX_BITS;
                else if (write)
                    state_d = TX_INHIBIT;
            end
            RX_BITS: begin
                if (fall && bit_cnt_q == 4'd10)
                    state_d = RX_CHECK;
                else if (!fall && timeout)
                    state_d = IDLE;
            end
            RX_CHECK:   state_d = IDLE;
            TX_INHIBIT: if (cnt_q == CW'(INHIBIT_CYCLES - 1)) state_d = TX_START;
            TX_START:   if (cnt_q == CW'(START_CYCLES - 1))   state_d = TX_BITS;
            TX_BITS: begin
                if (fall && bit_cnt_q == 4'd9)
                    state_d = TX_ACK;
                else if (!fall && timeout)
                    state_d = IDLE;
            end
            TX_ACK: begin
                if (fall)
                    state_d = TX_WAIT_IDLE;
                else if (timeout)
                    state_d = IDLE;
            end
            TX_WAIT_IDLE: if (lines_idle || timeout) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        timeout_exit = (state_d == IDLE) &&
                       ((state_q == RX_BITS) || (state_q == TX_BITS) || (state_q == TX_ACK) ||
                        ((state_q == TX_WAIT_IDLE) && !lines_idle));

        // Our own inhibit pulls ps2_clk low, so only device-clocked states restart on edges
        if ((state_d != state_q) || (state_q == IDLE) || (state_q == RX_CHECK) ||
            (fall && ((state_q == RX_BITS) || (state_q == TX_BITS) || (state_q == TX_ACK))))
            cnt_d = '0;
        else
            cnt_d = cnt_q + 1'b1;

        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        if (state_q == IDLE) begin
            bit_cnt_d = (state_d == RX_BITS) ? 4'd1 : 4'd0;
            if (fall)
                rx_shift_d = {filt_data_q, rx_shift_q[10:1]};
            if (state_d == TX_INHIBIT)
                tx_shift_d = {~^tx_data, tx_data};
        end else if ((state_q == RX_BITS) && fall) begin
            bit_cnt_d  = bit_cnt_q + 4'd1;
            rx_shift_d = {filt_data_q, rx_shift_q[10:1]};
        end else if ((state_q == TX_BITS) && fall) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
        end

        clk_oe_d  = (state_d == TX_INHIBIT) || (state_d == TX_START);
        data_oe_d = data_oe_q;
        if (state_d == TX_START)
            data_oe_d = 1'b1;
        else if (state_d != TX_BITS)
            data_oe_d = 1'b0;
        else if ((state_q == TX_BITS) && fall)
            data_oe_d = ~tx_shift_q[bit_cnt_q];

        rx_data_d   = rx_data_q;
        read_data_d = 1'b0;
        err_d       = 1'b0;
        if (state_q == RX_CHECK) begin
            if (frame_good) begin
                rx_data_d   = rx_shift_q[8:1];
                read_data_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
        if ((state_q == TX_ACK) && fall && filt_data_q)
            err_d = 1'b1;
        if (timeout_exit)
            err_d = 1'b1;

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q      <= 2'b11;
            data_sync_q     <= 2'b11;
            filt_clk_q      <= 1'b1;
            filt_data_q     <= 1'b1;
            filt_clk_cnt_q  <= '0;
            filt_data_cnt_q <= '0;
            clk_prev_q      <= 1'b1;
            cnt_q           <= '0;
            bit_cnt_q       <= '0;
            rx_shift_q      <= '0;
            tx_shift_q      <= '0;
            clk_oe_q        <= 1'b0;
            data_oe_q       <= 1'b0;
            rx_data_q       <= '0;
            read_data_q     <= 1'b0;
            busy_q          <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            clk_sync_q      <= clk_sync_d;
            data_sync_q     <= data_sync_d;
            filt_clk_q      <= filt_clk_d;
            filt_data_q     <= filt_data_d;
            filt_clk_cnt_q  <= filt_clk_cnt_d;
            filt_data_cnt_q <= filt_data_cnt_d;
            clk_prev_q      <= clk_prev_d;
            cnt_q           <= cnt_d;
            bit_cnt_q       <= bit_cnt_d;
            rx_shift_q      <= rx_shift_d;
            tx_shift_q      <= tx_shift_d;
            clk_oe_q        <= clk_oe_d;
            data_oe_q       <= data_oe_d;
            rx_data_q       <= rx_data_d;
            read_data_q     <= read_data_d;
            busy_q          <= busy_d;
            err_q           <= err_d;
        end
    end

endmodule

// File: tb/tb_ps2_interface.sv
// Bench for ps2_interface: PS/2 device model on pulled-up lines, scoreboard of read_data/err events.
`timescale 1ns/1ps
module tb_ps2_interface;

    localparam int FILT = 8;
    localparam int INH  = 300;
    localparam int STRT = 80;
    localparam int TOUT = 3000;
    localparam int HALF = 60;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       write = 1'b0;
    wire  [7:0] rx_data;
    wire        read_data, busy, err;
    wire        ps2_clk, ps2_data;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    pullup (ps2_clk);
    pullup (ps2_data);
    assign ps2_clk  = dev_clk_low  ? 1'b0 : 1'bz;
    assign ps2_data = dev_data_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    ps2_interface #(
        .FILTER_CYCLES (FILT),
        .INHIBIT_CYCLES(INH),
        .START_CYCLES  (STRT),
        .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .tx_data  (tx_data),
        .write    (write),
        .rx_data  (rx_data),
        .read_data(read_data),
        .busy     (busy),
        .err      (err)
    );

    int         total = 0;
    int         bad = 0;
    logic [8:0] exp_q[$];   // {is_err, byte}; err entries carry byte 0

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (read_data || err)) begin
            check("rd_err_excl", {31'b0, read_data & err}, 32'd0);
            if (exp_q.size() == 0)
                check("ev_pending", exp_q.size(), 32'd1);
            else
                check("ev", {23'b0, err, (err ? 8'h00 : rx_data)}, {23'b0, exp_q.pop_front()});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_half();
        repeat (HALF) @(negedge clk);
    endtask

    task automatic dev_send(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        if (nbits == 11 && !bad_par)
            exp_q.push_back({1'b0, b});
        else
            exp_q.push_back(9'h100);
        for (int i = 0; i < nbits; i++) begin
            dev_data_low = !f[i];
            wait_half();
            dev_clk_low = 1'b1;
            wait_half();
            if (i == 2)
                check("rx_busy", {31'b0, busy}, 32'd1);
            dev_clk_low = 1'b0;
        end
        wait_half();
        dev_data_low = 1'b0;
    endtask

    task automatic drain(input int budget, output int waited);
        waited = 0;
        while (exp_q.size() != 0 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        check("drain", exp_q.size(), 32'd0);
    endtask

    task automatic dev_host_rx(input bit ack, output logic [10:0] bits, output int n_inh, output int n_st);
        int g;
        n_inh = 0;
        n_st  = 0;
        g     = 0;
        while (ps2_clk !== 1'b0 && g < 1000) begin
            @(negedge clk);
            g++;
        end
        check("inh_seen", {31'b0, ps2_clk}, 32'd0);
        g = 0;
        while (ps2_clk === 1'b0 && g < 100000) begin
            if (ps2_data === 1'b1) n_inh++;
            else                   n_st++;
            @(negedge clk);
            g++;
        end
        bits[0] = ps2_data;
        wait_half();
        for (int k = 1; k <= 10; k++) begin
            dev_clk_low = 1'b1;
            wait_half();
            bits[k] = ps2_data;
            dev_clk_low = 1'b0;
            wait_half();
        end
        if (ack) dev_data_low = 1'b1;
        wait_half();
        dev_clk_low = 1'b1;
        wait_half();
        dev_clk_low = 1'b0;
        wait_half();
        dev_data_low = 1'b0;
    endtask

    task automatic wait_not_busy(input string tag, input int budget);
        int g;
        g = 0;
        while (busy !== 1'b0 && g < budget) begin
            @(negedge clk);
            g++;
        end
        check(tag, {31'b0, busy}, 32'd0);
    endtask

    task automatic run_tx(input logic [7:0] b, input bit ack, input bit poke);
        logic [10:0] bits;
        int          ni, ns;
        tx_data = b;
        write   = 1'b1;
        @(negedge clk);
        write   = 1'b0;
        tx_data = 8'h00;
        if (!ack) exp_q.push_back(9'h100);
        fork
            dev_host_rx(ack, bits, ni, ns);
            begin
                if (poke) begin
                    repeat (50) @(negedge clk);
                    tx_data = 8'h55;
                    write   = 1'b1;
                    @(negedge clk);
                    write   = 1'b0;
                    tx_data = 8'h00;
                end
            end
        join
        check("tx_inhibit_len", ni, INH);
        check("tx_start_len", ns, STRT);
        check("tx_start_bit", {31'b0, bits[0]}, 32'd0);
        check("tx_byte", {24'b0, bits[8:1]}, {24'b0, b});
        check("tx_parity", {31'b0, bits[9]}, {31'b0, ~^b});
        check("tx_stop", {31'b0, bits[10]}, 32'd1);
        wait_not_busy("tx_busy_fall", 1000);
    endtask

    initial begin
        int w, lows, busy_hi;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_rd", {31'b0, read_data}, 32'd0);
        check("rst_rx_data", {24'b0, rx_data}, 32'd0);
        check("rst_ps2_clk", {31'b0, ps2_clk}, 32'd1);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // Reset in the middle of the inhibit phase
        tx_data = 8'hA5;
        write   = 1'b1;
        @(negedge clk);
        write   = 1'b0;
        repeat (100) @(negedge clk);
        check("t1_inhibit", {31'b0, ps2_clk}, 32'd0);
        check("t1_busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("t1_clk_rel", {31'b0, ps2_clk}, 32'd1);
        check("t1_data_rel", {31'b0, ps2_data}, 32'd1);
        check("t1_busy0", {31'b0, busy}, 32'd0);
        check("t1_err0", {31'b0, err}, 32'd0);
        check("t1_rd0", {31'b0, read_data}, 32'd0);
        check("t1_rx0", {24'b0, rx_data}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);

        // Good frame, then the same frame with a flipped parity bit
        dev_send(8'h1C, 1'b0, 11);
        drain(500, w);
        check("t2_rx", {24'b0, rx_data}, 32'h1C);
        check("t2_busy", {31'b0, busy}, 32'd0);
        dev_send(8'h1C, 1'b1, 11);
        drain(500, w);
        check("t3_rx_kept", {24'b0, rx_data}, 32'h1C);
        dev_send(8'hA7, 1'b0, 11);
        drain(500, w);
        check("t3b_rx", {24'b0, rx_data}, 32'hA7);

        // Host transmit with ACK, extra write while busy must be ignored
        run_tx(8'hFF, 1'b1, 1'b1);
        lows = 0;
        repeat (400) begin
            @(negedge clk);
            if (ps2_clk === 1'b0) lows++;
        end
        check("t4_no_retx", lows, 0);
        check("t4_q_empty", exp_q.size(), 32'd0);

        // Host transmit, device withholds ACK
        run_tx(8'hFF, 1'b0, 1'b0);
        drain(200, w);
        run_tx(8'h3C, 1'b1, 1'b0);

        // Device stops clocking mid-frame
        dev_send(8'h1C, 1'b0, 5);
        drain(TOUT + 1000, w);
        check("t6_to_min", {31'b0, (w >= TOUT - 200)}, 32'd1);
        check("t6_busy", {31'b0, busy}, 32'd0);
        dev_send(8'h1C, 1'b0, 11);
        drain(500, w);
        check("t6_rx", {24'b0, rx_data}, 32'h1C);

        // Short glitch on ps2_clk in IDLE
        dev_clk_low = 1'b1;
        repeat (2) @(negedge clk);
        dev_clk_low = 1'b0;
        busy_hi = 0;
        repeat (80) begin
            @(negedge clk);
            if (busy === 1'b1) busy_hi++;
        end
        check("t6_glitch", busy_hi, 0);
        check("end_q_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
